// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and error codes shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-addressed data memory bus with req/ack handshake.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: store strobes/lane replication, access checks, load extraction and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        illegal,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] lane,
  output logic [31:0] ext
);
  logic [31:0] shifted;
  logic [15:0] half;
  logic        sgn;
  always_comb begin
    illegal  = write ? (funct3 > F3_W) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misalign = funct3[1:0] == 2'b01 ? addr_lo[0] : funct3[1:0] == 2'b10 ? |addr_lo : 1'b0;
    wstrb    = !write ? 4'b0000 :
               funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
               funct3[1:0] == 2'b01 ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
    lane     = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
               funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    shifted  = rdata >> {addr_lo, 3'b000};
    half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sgn      = !funct3[2];
    ext      = funct3[1:0] == 2'b00 ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
               funct3[1:0] == 2'b01 ? {{16{sgn & half[15]}}, half} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM with capture registers and bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  load_store_unit_if.master mem
);
  state_t      state_q, state_d;
  logic        write_q, write_d, we_q, we_d, err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic        idle, illegal, misalign;
  logic [3:0]  strb;
  logic [31:0] lane, ext;
  assign idle = state_q == IDLE;
  // In IDLE the aligner checks the incoming request; afterwards it sees the captured one.
  lsu_align u_align (
    .write(idle ? req_write : write_q),
    .funct3(idle ? funct3 : funct3_q),
    .addr_lo(idle ? addr[1:0] : addr_q[1:0]),
    .wdata(wdata),
    .rdata(mem.mem_rdata),
    .illegal(illegal),
    .misalign(misalign),
    .wstrb(strb),
    .lane(lane),
    .ext(ext)
  );
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d  = req_write;
        funct3_d = funct3;
        addr_d   = addr;
        rdata_d  = '0;
        err_d    = illegal | misalign;
        code_d   = illegal ? ERR_ILLEGAL : misalign ? ERR_MISALIGN : ERR_NONE;
        state_d  = err_d ? RESP : BUS;
        we_d     = req_write & !err_d;
        wstrb_d  = err_d ? 4'b0000 : strb;
        wdata_d  = lane;
        cnt_d    = '0;
      end
      BUS: if (mem.mem_ack) begin
        state_d = RESP;
        rdata_d = write_q ? '0 : ext;
      end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        rdata_d = '0;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end
  assign req_ready     = idle;
  assign stall         = !idle;
  assign resp_valid    = state_q == RESP;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_err_code = code_q;
  assign mem.mem_req   = state_q == BUS;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with TIMEOUT_CYCLES=4.
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err_code;
  int total = 0, bad = 0;
  load_store_unit_if m();
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_err_code(resp_err_code), .mem(m)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_write = w; funct3 = f; addr = a; wdata = d; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic ack_now(input logic [31:0] rd);
    m.mem_ack = 1'b1; m.mem_rdata = rd;
    tick;
    m.mem_ack = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if ({stall, resp_valid, resp_err, m.mem_req, m.mem_we} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {stall, resp_valid, resp_err, m.mem_req, m.mem_we}); end
    total++; if ({resp_rdata, m.mem_addr, m.mem_wdata} !== 96'h0) begin bad++; $display("FAIL reset_buses got=%h exp=0", {resp_rdata, m.mem_addr, m.mem_wdata}); end
    total++; if ({m.mem_wstrb, resp_err_code} !== 6'b0) begin bad++; $display("FAIL reset_strb_code got=%b exp=0", {m.mem_wstrb, resp_err_code}); end
    reset = 1'b0;
  endtask
  task automatic test_sb;
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    total++; if ({m.mem_req, m.mem_we, m.mem_wstrb} !== 6'b11_1000) begin bad++; $display("FAIL sb_ctl got=%b exp=111000", {m.mem_req, m.mem_we, m.mem_wstrb}); end
    total++; if (m.mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", m.mem_addr); end
    total++; if (m.mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", m.mem_wdata); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL sb_early_resp got=%b exp=0", resp_valid); end
    ack_now(32'hFFFF_FFFF);
    total++; if ({resp_valid, resp_err, m.mem_req} !== 3'b100) begin bad++; $display("FAIL sb_resp got=%b exp=100", {resp_valid, resp_err, m.mem_req}); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL sb_rdata got=%h exp=0", resp_rdata); end
    tick;
    total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL sb_idle got=%b exp=01", {resp_valid, req_ready}); end
    issue(1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF);
    total++; if ({m.mem_wstrb, m.mem_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin bad++; $display("FAIL sh_lanes got=%h exp=cbeefbeef", {m.mem_wstrb, m.mem_wdata}); end
    ack_now(32'h0);
    tick;
  endtask
  task automatic test_loads;
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    total++; if ({m.mem_req, m.mem_we, m.mem_wstrb} !== 6'b10_0000) begin bad++; $display("FAIL lb_ctl got=%b exp=100000", {m.mem_req, m.mem_we, m.mem_wstrb}); end
    ack_now(32'h80FF_1234);
    total++; if (resp_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", resp_rdata); end
    tick;
    issue(1'b0, 3'b100, 32'h0000_1003, 32'h0);
    ack_now(32'h80FF_1234);
    total++; if (resp_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", resp_rdata); end
    tick;
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    ack_now(32'h8001_7FFF);
    total++; if (resp_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%h exp=ffff8001", resp_rdata); end
    tick;
    issue(1'b0, 3'b101, 32'h0000_2000, 32'h0);
    ack_now(32'h8001_8FFF);
    total++; if (resp_rdata !== 32'h0000_8FFF) begin bad++; $display("FAIL lhu_data got=%h exp=00008fff", resp_rdata); end
    tick;
  endtask
  task automatic test_errors;
    issue(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    total++; if ({resp_valid, resp_err, resp_err_code, m.mem_req} !== 5'b11010) begin bad++; $display("FAIL lw_misalign got=%b exp=11010", {resp_valid, resp_err, resp_err_code, m.mem_req}); end
    tick;
    total++; if ({resp_valid, m.mem_req, req_ready} !== 3'b001) begin bad++; $display("FAIL misalign_after got=%b exp=001", {resp_valid, m.mem_req, req_ready}); end
    issue(1'b1, 3'b011, 32'h0000_3000, 32'h1);
    total++; if ({resp_valid, resp_err, resp_err_code, m.mem_req, m.mem_we} !== 6'b111000) begin bad++; $display("FAIL st_illegal got=%b exp=111000", {resp_valid, resp_err, resp_err_code, m.mem_req, m.mem_we}); end
    tick;
    issue(1'b0, 3'b110, 32'h0000_3001, 32'h0);
    total++; if ({resp_valid, resp_err_code} !== 3'b110) begin bad++; $display("FAIL ld_illegal got=%b exp=110", {resp_valid, resp_err_code}); end
    tick;
    issue(1'b1, 3'b001, 32'h0000_3001, 32'h0);
    total++; if ({resp_valid, resp_err_code, resp_rdata} !== {3'b101, 32'h0}) begin bad++; $display("FAIL sh_misalign got=%h exp=500000000", {resp_valid, resp_err_code, resp_rdata}); end
    tick;
  endtask
  task automatic test_timeout;
    int n = 0;
    issue(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678);
    total++; if ({m.mem_wstrb, m.mem_wdata} !== {4'hF, 32'h1234_5678}) begin bad++; $display("FAIL sw_lanes got=%h exp=f12345678", {m.mem_wstrb, m.mem_wdata}); end
    for (int i = 0; i < 20 && m.mem_req; i++) begin n++; tick; end
    total++; if (n !== 4) begin bad++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
    total++; if ({resp_valid, resp_err, resp_err_code, resp_rdata} !== {4'b1111, 32'h0}) begin bad++; $display("FAIL to_resp got=%h exp=f00000000", {resp_valid, resp_err, resp_err_code, resp_rdata}); end
    tick;
    issue(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678);
    tick; tick; tick;
    total++; if (m.mem_req !== 1'b1) begin bad++; $display("FAIL to_4th_req got=%b exp=1", m.mem_req); end
    ack_now(32'h0);
    total++; if ({resp_valid, resp_err, resp_err_code} !== 4'b1000) begin bad++; $display("FAIL to_ack_wins got=%b exp=1000", {resp_valid, resp_err, resp_err_code}); end
    tick;
  endtask
  task automatic test_back_to_back;
    int busy_bad = 0;
    req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_5000; req_valid = 1'b1;
    tick;
    addr = 32'h0000_7777_0;
    for (int i = 0; i < 3; i++) begin
      if ({stall, req_ready, m.mem_req, resp_valid} !== 4'b1010 || m.mem_addr !== 32'h0000_5000) busy_bad++;
      tick;
    end
    total++; if (busy_bad !== 0) begin bad++; $display("FAIL b2b_busy got=%0d bad cycles exp=0", busy_bad); end
    addr = 32'h0000_6001; funct3 = 3'b100;
    ack_now(32'hDEAD_BEEF);
    total++; if ({resp_valid, req_ready, resp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin bad++; $display("FAIL b2b_resp got=%h exp=2deadbeef", {resp_valid, req_ready, resp_rdata}); end
    tick;
    total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL b2b_idle got=%b exp=01", {resp_valid, req_ready}); end
    tick;
    req_valid = 1'b0;
    total++; if ({m.mem_req, m.mem_addr} !== {1'b1, 32'h0000_6000}) begin bad++; $display("FAIL b2b_second got=%h exp=100006000", {m.mem_req, m.mem_addr}); end
    ack_now(32'h0000_AB00);
    total++; if (resp_rdata !== 32'h0000_00AB) begin bad++; $display("FAIL b2b_lbu got=%h exp=000000ab", resp_rdata); end
    tick;
  endtask
  task automatic test_reset_mid;
    issue(1'b1, 3'b010, 32'h0000_8000, 32'hCAFE_F00D);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if ({req_ready, stall, resp_valid, m.mem_req, m.mem_we, m.mem_wstrb} !== 9'b1_0000_0000) begin bad++; $display("FAIL rst_mid got=%b exp=100000000", {req_ready, stall, resp_valid, m.mem_req, m.mem_we, m.mem_wstrb}); end
    ack_now(32'h1111_1111);
    total++; if ({resp_valid, m.mem_req, req_ready} !== 3'b001) begin bad++; $display("FAIL stray_ack got=%b exp=001", {resp_valid, m.mem_req, req_ready}); end
    tick;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stray_ack_late got=%b exp=0", resp_valid); end
  endtask
  initial begin
    m.mem_ack = 1'b0;
    m.mem_rdata = '0;
    test_reset;
    test_sb;
    test_loads;
    test_errors;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
